// File: rtl/cic3_row_readout_serializer.sv
// cic3_row_readout_serializer
// Captures the CIC3 filter row outputs on each decimated sample strobe and
// streams them as one framed, MSB-first serial bitstream:
//   8-bit header, SEQ_WIDTH-bit sequence number, then every enabled channel.
// All outputs are registered. The next-state values are computed first and
// the serial bit for the following cycle is selected from them, so the first
// header bit appears on sdo the cycle after capture.
`timescale 1ns/1ps
module cic3_row_readout_serializer #(
  parameter int         NUM_CHANNELS = 24,
  parameter int         WORD_WIDTH   = 25,
  parameter logic [7:0] HEADER       = 8'hA5,
  parameter int         SEQ_WIDTH    = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               enable,
  input  logic                               sample_strobe,
  input  logic [NUM_CHANNELS*WORD_WIDTH-1:0] data_in,
  input  logic [NUM_CHANNELS-1:0]            channel_mask,
  output logic                               sdo,
  output logic                               sdo_valid,
  output logic                               frame_start,
  output logic                               busy,
  output logic                               overrun
);

  localparam int DATA_W = NUM_CHANNELS * WORD_WIDTH;
  localparam int CNT_W  = $clog2(WORD_WIDTH + SEQ_WIDTH + 8);
  localparam int CH_W   = $clog2(NUM_CHANNELS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    SEQ  = 2'd2,
    DATA = 2'd3
  } state_t;

  // Lowest-index set bit of the remaining mask (channels go out ascending).
  function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CHANNELS-1:0] m);
    logic [CH_W-1:0] idx;
    idx = {CH_W{1'b0}};
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (m[i]) begin
        idx = CH_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Registered state. cnt_r is the bit index currently on sdo within the
  // current field; mask_r holds the channels still to send after chan_r.
  state_t                  state_r, state_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;
  logic [CH_W-1:0]         chan_r, chan_s;
  logic [NUM_CHANNELS-1:0] mask_r, mask_s;
  logic [DATA_W-1:0]       data_r, data_s;
  logic [SEQ_WIDTH-1:0]    seq_sh_r, seq_sh_s;
  logic [SEQ_WIDTH-1:0]    seq_cnt_r, seq_cnt_s;
  logic                    overrun_r, overrun_s;
  logic                    sdo_r, sdo_s;
  logic                    sdo_valid_r, sdo_valid_s;
  logic                    frame_start_r, frame_start_s;
  logic                    busy_r, busy_s;

  logic                    in_frame_s;
  logic                    last_bit_s;
  logic                    capture_s;
  logic [WORD_WIDTH-1:0]   word_s;
  logic [WORD_WIDTH-1:0]   word_shift_s;
  logic [7:0]              hdr_shift_s;
  logic [SEQ_WIDTH-1:0]    seq_shift_s;

  // Next-state, capture, sequence/overrun bookkeeping and next serial bit.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    chan_s        = chan_r;
    mask_s        = mask_r;
    data_s        = data_r;
    seq_sh_s      = seq_sh_r;
    seq_cnt_s     = seq_cnt_r;
    overrun_s     = overrun_r;
    sdo_s         = 1'b0;
    sdo_valid_s   = 1'b0;
    frame_start_s = 1'b0;
    busy_s        = 1'b0;
    word_s        = {WORD_WIDTH{1'b0}};
    word_shift_s  = {WORD_WIDTH{1'b0}};
    hdr_shift_s   = 8'h00;
    seq_shift_s   = {SEQ_WIDTH{1'b0}};

    in_frame_s = (state_r != IDLE);
    // The last frame bit is the final bit of the seq field or of a data word
    // with no channels left to send.
    last_bit_s = ((state_r == SEQ) || (state_r == DATA)) &&
                 (cnt_r == {CNT_W{1'b0}}) && (mask_r == {NUM_CHANNELS{1'b0}});
    capture_s  = enable && sample_strobe && (!in_frame_s || last_bit_s);

    if (!enable) begin
      // Abort: a partial frame is never resumed.
      state_s   = IDLE;
      cnt_s     = {CNT_W{1'b0}};
      chan_s    = {CH_W{1'b0}};
      mask_s    = {NUM_CHANNELS{1'b0}};
      seq_cnt_s = {SEQ_WIDTH{1'b0}};
      overrun_s = 1'b0;
    end else begin
      // Every strobe advances the counter, so dropped samples show as gaps.
      if (sample_strobe) begin
        seq_cnt_s = seq_cnt_r + SEQ_WIDTH'(1);
      end else begin
        seq_cnt_s = seq_cnt_r;
      end

      if (sample_strobe && in_frame_s && !last_bit_s) begin
        overrun_s = 1'b1;
      end else begin
        overrun_s = overrun_r;
      end

      if (capture_s) begin
        state_s  = HDR;
        cnt_s    = CNT_W'(7);
        chan_s   = {CH_W{1'b0}};
        mask_s   = channel_mask;
        data_s   = data_in;
        seq_sh_s = seq_cnt_r;
      end else begin
        case (state_r)
          IDLE: begin
            state_s = IDLE;
          end
          HDR: begin
            if (cnt_r == {CNT_W{1'b0}}) begin
              state_s = SEQ;
              cnt_s   = CNT_W'(SEQ_WIDTH - 1);
            end else begin
              cnt_s   = cnt_r - CNT_W'(1);
            end
          end
          SEQ, DATA: begin
            if (cnt_r != {CNT_W{1'b0}}) begin
              cnt_s = cnt_r - CNT_W'(1);
            end else if (mask_r != {NUM_CHANNELS{1'b0}}) begin
              // Jump straight to the next enabled channel: no bubble.
              state_s = DATA;
              chan_s  = lowest_set(mask_r);
              mask_s  = mask_r & (mask_r - {{(NUM_CHANNELS-1){1'b0}}, 1'b1});
              cnt_s   = CNT_W'(WORD_WIDTH - 1);
            end else begin
              state_s = IDLE;
              cnt_s   = {CNT_W{1'b0}};
            end
          end
          default: begin
            state_s = IDLE;
            cnt_s   = {CNT_W{1'b0}};
          end
        endcase
      end
    end

    // Select the bit that will be on sdo during the next cycle.
    word_s       = data_s[int'(chan_s) * WORD_WIDTH +: WORD_WIDTH];
    word_shift_s = word_s >> cnt_s;
    hdr_shift_s  = HEADER >> cnt_s;
    seq_shift_s  = seq_sh_s >> cnt_s;
    case (state_s)
      IDLE:    sdo_s = 1'b0;
      HDR:     sdo_s = hdr_shift_s[0];
      SEQ:     sdo_s = seq_shift_s[0];
      DATA:    sdo_s = word_shift_s[0];
      default: sdo_s = 1'b0;
    endcase
    sdo_valid_s   = (state_s != IDLE);
    busy_s        = (state_s != IDLE);
    frame_start_s = (state_s == HDR) && (cnt_s == CNT_W'(7));
  end

  // State, shadow and output registers; async active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      chan_r        <= {CH_W{1'b0}};
      mask_r        <= {NUM_CHANNELS{1'b0}};
      data_r        <= {DATA_W{1'b0}};
      seq_sh_r      <= {SEQ_WIDTH{1'b0}};
      seq_cnt_r     <= {SEQ_WIDTH{1'b0}};
      overrun_r     <= 1'b0;
      sdo_r         <= 1'b0;
      sdo_valid_r   <= 1'b0;
      frame_start_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      chan_r        <= chan_s;
      mask_r        <= mask_s;
      data_r        <= data_s;
      seq_sh_r      <= seq_sh_s;
      seq_cnt_r     <= seq_cnt_s;
      overrun_r     <= overrun_s;
      sdo_r         <= sdo_s;
      sdo_valid_r   <= sdo_valid_s;
      frame_start_r <= frame_start_s;
      busy_r        <= busy_s;
    end
  end

  assign sdo         = sdo_r;
  assign sdo_valid   = sdo_valid_r;
  assign frame_start = frame_start_r;
  assign busy        = busy_r;
  assign overrun     = overrun_r;

endmodule

// File: tb/tb_cic3_row_readout_serializer.sv
// Scoreboard bench: stimulus pushes the expected frame bits into a queue,
// a negedge monitor pops and compares whenever sdo_valid is high.
`timescale 1ns/1ps
module tb_cic3_row_readout_serializer;

  localparam int NCH = 24;
  localparam int WW  = 25;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            enable;
  logic            sample_strobe;
  logic [NCH*WW-1:0] data_in;
  logic [NCH-1:0]  channel_mask;
  logic            sdo, sdo_valid, frame_start, busy, overrun;

  cic3_row_readout_serializer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .sample_strobe (sample_strobe),
    .data_in       (data_in),
    .channel_mask  (channel_mask),
    .sdo           (sdo),
    .sdo_valid     (sdo_valid),
    .frame_start   (frame_start),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [1:0] exp_q[$];   // {frame_start, sdo}
  logic [1:0] mon_e;
  logic [3:0] exp_seq;
  logic [7:0] hdr = 8'hA5;
  logic [NCH*WW-1:0] din;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Expected bit sequence for one frame, built from the frame definition.
  task automatic push_frame(input logic [NCH*WW-1:0] d, input logic [NCH-1:0] m,
                            input logic [3:0] s);
    for (int i = 7; i >= 0; i--) exp_q.push_back({(i == 7), hdr[i]});
    for (int i = 3; i >= 0; i--) exp_q.push_back({1'b0, s[i]});
    for (int k = 0; k < NCH; k++)
      if (m[k])
        for (int b = WW - 1; b >= 0; b--) exp_q.push_back({1'b0, d[k*WW + b]});
  endtask

  // Called just after a posedge; strobe is sampled at the next posedge.
  task automatic do_strobe(input logic [NCH*WW-1:0] d, input logic [NCH-1:0] m,
                           input logic accept);
    data_in = d;
    channel_mask = m;
    sample_strobe = 1'b1;
    if (accept) push_frame(d, m, exp_seq);
    if (enable) exp_seq = exp_seq + 4'd1;
    @(posedge clk);
    #1 sample_strobe = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    logic done;
    done = 1'b0;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) done = 1'b1;
    end
    chk(nm, {63'd0, done}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic en_pulse();
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 enable = 1'b1;
    exp_seq = 4'd0;
  endtask

  // Monitor: compare each valid bit against the scoreboard.
  always @(negedge clk) begin
    chk("busy_eq_valid", {63'd0, busy}, {63'd0, sdo_valid});
    if (sdo_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_bit", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sdo_bit", {63'd0, sdo}, {63'd0, mon_e[0]});
        chk("frame_start", {63'd0, frame_start}, {63'd0, mon_e[1]});
      end
    end else begin
      chk("idle_outputs", {62'd0, sdo, frame_start}, 64'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; sample_strobe = 1'b0;
    data_in = '0; channel_mask = '0; exp_seq = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {59'd0, sdo, sdo_valid, frame_start, busy, overrun}, 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1 enable = 1'b1;

    // 1: full mask, channel k = k+1 -> 612 bits, seq 0
    for (int k = 0; k < NCH; k++) din[k*WW +: WW] = 25'(k + 1);
    do_strobe(din, 24'hFFFFFF, 1'b1);
    wait_idle("full_frame_done");

    // 2: mask 5 -> ch0 and ch2 adjacent, ch1 skipped (seq 1)
    din = '0;
    din[0*WW +: WW] = 25'h1FFFFFF;
    din[1*WW +: WW] = 25'h0AAAAAA;
    din[2*WW +: WW] = 25'h0000001;
    do_strobe(din, 24'h000005, 1'b1);
    wait_idle("mask5_frame_done");

    // 3: empty mask (12 bits), second strobe on the last bit -> seq 1 with no gap
    en_pulse();
    do_strobe(din, 24'h000000, 1'b1);
    repeat (11) @(posedge clk);
    #1;
    do_strobe(din, 24'h000000, 1'b1);
    wait_idle("back_to_back_done");

    // 4: strobe at bit 100 -> overrun, dropped; next frame seq 2
    en_pulse();
    for (int k = 0; k < NCH; k++) din[k*WW +: WW] = 25'(k * 7919 + 3);
    do_strobe(din, 24'hFFFFFF, 1'b1);
    repeat (100) @(posedge clk);
    #1;
    do_strobe(25'h155 ^ din, 24'hFFFFFF, 1'b0);
    @(negedge clk);
    chk("overrun_set", {63'd0, overrun}, 64'd1);
    wait_idle("overrun_frame_done");
    do_strobe(din, 24'h800001, 1'b1);
    wait_idle("seq_gap_frame_done");
    chk("overrun_sticky", {63'd0, overrun}, 64'd1);
    en_pulse();
    @(negedge clk);
    chk("overrun_cleared", {63'd0, overrun}, 64'd0);
    @(posedge clk);
    #1;

    // 5: enable dropped at bit 300
    do_strobe(din, 24'hFFFFFF, 1'b1);
    repeat (300) @(posedge clk);
    #1 enable = 1'b0;
    @(posedge clk);
    #1 exp_q.delete();
    @(negedge clk);
    chk("abort_valid_busy", {62'd0, sdo_valid, busy}, 64'd0);
    @(posedge clk);
    #1 enable = 1'b1;
    exp_seq = 4'd0;
    do_strobe(din, 24'h0000F0, 1'b1);
    wait_idle("after_abort_frame_done");

    // 6: reset mid-DATA, then a clean frame with seq 0
    do_strobe(din, 24'hFFFFFF, 1'b1);
    do_strobe(din, 24'hFFFFFF, 1'b0);
    repeat (48) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", {59'd0, sdo, sdo_valid, frame_start, busy, overrun}, 64'd0);
    exp_q.delete();
    exp_seq = 4'd0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < NCH; k++) din[k*WW +: WW] = 25'(25'h1000000 >> (k % 25));
    do_strobe(din, 24'h00A00F, 1'b1);
    wait_idle("post_reset_frame_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
